mu0_phase_sequencer: RTL
========================

Name: mu0_phase_sequencer

Overview:
Run-control sequencer for the MU0-style core. It generates the one-hot phase strobes fetch/exec1/exec2 that drive the instruction decoder, and uses the decoder's Extra flag to choose 2-cycle or 3-cycle instructions. Detects STP and parks the core. Adds external run/step/halt control and a retired-instruction counter for the debug/loader side.

Parameters:
OP_W, 4, opcode width
STP_OP, 4'b0111, opcode that stops the core
ICNT_W, 16, width of instr_count (and cycle_count)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run_req  in  1  pulse: start free-running from IDLE
step_req  in  1  pulse: execute exactly one instruction from IDLE
halt_req  in  1  pulse: stop at next instruction boundary
op  in  OP_W  current opcode, valid throughout EXEC1
extra  in  1  decoder Extra (LDA/ADD/SUB need EXEC2), valid in EXEC1
fetch  out  1  phase strobe
exec1  out  1  phase strobe
exec2  out  1  phase strobe
busy  out  1  state is FETCH, EXEC1 or EXEC2
halted  out  1  state is IDLE
stopped  out  1  state is STOPPED (STP executed)
retire  out  1  final execute cycle of an instruction
instr_count  out  ICNT_W  retired-instruction count, wraps
cycle_count  out  ICNT_W  busy-cycle count (optional feature)

Behaviour:
- States: IDLE, FETCH, EXEC1, EXEC2, STOPPED. The state register is reset asynchronously to IDLE. Phase strobes are decoded from the state only (Moore), one-hot or all zero.
- Reset values: fetch=exec1=exec2=0, busy=0, halted=1, stopped=0, retire=0, instr_count=0, cycle_count=0, step_mode=0, halt_pend=0.
- IDLE:
  - step_req → FETCH with step_mode=1.
  - else run_req → FETCH with step_mode=0.
  - Priority when pulses coincide: halt_req > step_req > run_req. halt_req in IDLE keeps IDLE and leaves nothing pending.
- FETCH → EXEC1 unconditionally.
- EXEC1:
  - op==STP_OP → STOPPED.
  - else extra=1 → EXEC2.
  - else boundary exit.
- EXEC2 → boundary exit. op and extra are not sampled in EXEC2.
- Boundary exit: if (halt_pend | halt_req | step_mode) → IDLE, clearing halt_pend and step_mode; else → FETCH.
- halt_req while busy sets halt_pend. The current instruction always completes; there is no mid-instruction abort.
- STOPPED is sticky. run_req, step_req and halt_req are ignored; only rst leaves it.
- retire = exec1&~extra | exec1&(op==STP_OP) | exec2. It is combinational from the state and EXEC1 inputs.
- Latency: run_req in cycle N gives fetch in N+1, exec1 in N+2, and exec2 (if extra) in N+3. Back-to-back instructions have no bubble between them.
- instr_count increments by 1 on each clock edge where retire=1, including STP. It wraps from 2^ICNT_W-1 to 0.
- rst asserted mid-instruction: immediate return to IDLE with all outputs at reset values. The partial instruction is not counted.

Optional Feature:
Macro MU0_SEQ_CYCLE_COUNT_EN.
- Defined: cycle_count increments on every clock edge with busy=1, wraps like instr_count, and resets to 0.
- Undefined: the cycle_count port remains, is driven constant 0, and no counter flops are inferred.

Decomposition:
- Package mu0_seq_pkg holds:
  - state enum (IDLE, FETCH, EXEC1, EXEC2, STOPPED), 3-bit;
  - OP_W;
  - STP_OP default;
  - opcode constants shared with the decoder (LDA..LSR).
- One sub-module, mu0_wrap_counter (params W; ports clk, rst, en, count): a wrapping counter instantiated for instr_count and, under the macro, cycle_count.

Test Plan:
- Reset released, no requests → halted=1, all strobes 0, instr_count=0 for 10 cycles.
- run_req, op=0010 (ADD), extra=1 → fetch, exec1, exec2 on cycles N+1..N+3; retire in exec2; instr_count=1; next cycle fetch again.
- Free-run with op=0100 (JMP), extra=0 → repeating fetch/exec1 pairs; halt_req during a fetch → instruction completes, then halted=1; instr_count equals number of exec1 cycles.
- step_req with op=0000, extra=1 → exactly one fetch/exec1/exec2 then IDLE; step_req and run_req in same cycle → single step only.
- op=0111 during exec1 → stopped=1 next cycle; run_req/step_req ignored for 20 cycles; rst → IDLE, stopped=0.
- ICNT_W=4, 17 retired JMP instructions → instr_count=1 (wrap); rst asserted during exec2 → immediate IDLE, counts cleared; with MU0_SEQ_CYCLE_COUNT_EN, 3 ADD instructions → cycle_count=9; without it, cycle_count stays 0.

Source files
------------

// File: rtl/mu0_seq_pkg.sv
// Shared types and constants for the MU0 run-control sequencer.
// The opcode constants match the instruction decoder's encoding.
package mu0_seq_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] STP_OP = 4'b0111;

    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_STA = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OP_W-1:0] OP_JMP = 4'b0100;
    localparam logic [OP_W-1:0] OP_JGE = 4'b0101;
    localparam logic [OP_W-1:0] OP_JNE = 4'b0110;
    localparam logic [OP_W-1:0] OP_STP = 4'b0111;
    localparam logic [OP_W-1:0] OP_LSL = 4'b1000;
    localparam logic [OP_W-1:0] OP_LSR = 4'b1001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXEC1   = 3'd2,
        ST_EXEC2   = 3'd3,
        ST_STOPPED = 3'd4
    } seq_state_t;

endpackage

// File: rtl/mu0_wrap_counter.sv
// Free-running wrapping up-counter with enable, cleared by reset.
module mu0_wrap_counter
    import mu0_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count up by one on each enabled edge; natural overflow gives the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mu0_phase_sequencer.sv
// Run-control sequencer for the MU0 core: one-hot fetch/exec1/exec2 phase
// strobes, 2- or 3-cycle instructions chosen by the decoder's extra flag,
// STP parking, run/step/halt control and a retired-instruction counter.
//
// Build option: define MU0_SEQ_CYCLE_COUNT_EN to enable the busy-cycle
// counter on cycle_count; otherwise cycle_count is tied to zero.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | halted, waiting for run_req or step_req
// ST_FETCH   | instruction fetch phase
// ST_EXEC1   | first execute phase, op/extra sampled here
// ST_EXEC2   | second execute phase for instructions needing it
// ST_STOPPED | STP executed, parked until reset
module mu0_phase_sequencer
    import mu0_seq_pkg::*;
#(
    parameter int              OP_W   = mu0_seq_pkg::OP_W,
    parameter logic [OP_W-1:0] STP_OP = mu0_seq_pkg::STP_OP,
    parameter int              ICNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic [OP_W-1:0]   op,
    input  logic              extra,
    output logic              fetch,
    output logic              exec1,
    output logic              exec2,
    output logic              busy,
    output logic              halted,
    output logic              stopped,
    output logic              retire,
    output logic [ICNT_W-1:0] instr_count,
    output logic [ICNT_W-1:0] cycle_count
);

    seq_state_t state;
    seq_state_t state_nxt;
    logic       step_mode;
    logic       step_mode_nxt;
    logic       halt_pend;
    logic       halt_pend_nxt;
    logic       boundary;
    logic       is_stp;

    assign is_stp = (op == STP_OP);

    // State register plus the run-mode flags that survive across instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            step_mode <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_mode <= step_mode_nxt;
            halt_pend <= halt_pend_nxt;
        end
    end

    // Next-state decode; instruction boundaries decide between IDLE and FETCH.
    always_comb begin
        state_nxt     = state;
        step_mode_nxt = step_mode;
        halt_pend_nxt = halt_pend;
        boundary      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // halt_req wins over both start requests and leaves nothing pending.
                if (halt_req) begin
                    state_nxt = ST_IDLE;
                end else if (step_req) begin
                    state_nxt     = ST_FETCH;
                    step_mode_nxt = 1'b1;
                end else if (run_req) begin
                    state_nxt     = ST_FETCH;
                    step_mode_nxt = 1'b0;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_EXEC1;
            end
            ST_EXEC1: begin
                if (is_stp) begin
                    state_nxt = ST_STOPPED;
                end else if (extra) begin
                    state_nxt = ST_EXEC2;
                end else begin
                    boundary = 1'b1;
                end
            end
            ST_EXEC2: begin
                boundary = 1'b1;
            end
            ST_STOPPED: begin
                state_nxt = ST_STOPPED;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A halt seen mid-instruction is remembered until the next boundary.
        if (busy && halt_req) begin
            halt_pend_nxt = 1'b1;
        end

        if (boundary) begin
            if (halt_pend || halt_req || step_mode) begin
                state_nxt     = ST_IDLE;
                halt_pend_nxt = 1'b0;
                step_mode_nxt = 1'b0;
            end else begin
                state_nxt = ST_FETCH;
            end
        end
    end

    assign fetch   = (state == ST_FETCH);
    assign exec1   = (state == ST_EXEC1);
    assign exec2   = (state == ST_EXEC2);
    assign busy    = fetch | exec1 | exec2;
    assign halted  = (state == ST_IDLE);
    assign stopped = (state == ST_STOPPED);

    // STP counts as retired in its exec1 cycle even though extra is ignored.
    assign retire = (exec1 & ~extra) | (exec1 & is_stp) | exec2;

    mu0_wrap_counter #(
        .W (ICNT_W)
    ) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (retire),
        .count (instr_count)
    );

`ifdef MU0_SEQ_CYCLE_COUNT_EN
    mu0_wrap_counter #(
        .W (ICNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (busy),
        .count (cycle_count)
    );
`else
    assign cycle_count = '0;
`endif

endmodule
